// File: rtl/param_rom_stream_ctrl.sv
// Streams a 2-cycle-latency parameter ROM onto a valid/ready stream, num_passes times per start.
// Address to data_out_valid is 3 cycles; issue is credit-limited so backpressure never loses a word.
module param_rom_stream_ctrl #(
  parameter int PRECISION   = 16,
  parameter int PARALLELISM = 1,
  parameter int OUT_DEPTH   = 32,
  parameter int PASS_WIDTH  = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int ADDR_WIDTH  = $clog2(OUT_DEPTH) + 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  input  logic [PASS_WIDTH-1:0]            num_passes,
  output logic                             busy,
  output logic                             done,
  output logic [ADDR_WIDTH-1:0]            rom_addr,
  output logic                             rom_ce,
  input  logic [PRECISION*PARALLELISM-1:0] rom_q,
  output logic [PRECISION-1:0]             data_out [PARALLELISM],
  output logic                             data_out_valid,
  input  logic                             data_out_ready
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int WW = PRECISION * PARALLELISM;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [PASS_WIDTH-1:0] pass_q, pass_d;
  logic [PASS_WIDTH-1:0] passes_q, passes_d;
  logic [1:0]            trk_q, trk_d;
  logic [WW-1:0]         mem_q [FIFO_DEPTH];
  logic [WW-1:0]         mem_d [FIFO_DEPTH];
  logic [PW-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  issue, push, pop;
  logic [CW:0]           occ;

  // Credits: words already buffered plus words still inside the ROM pipeline.
  assign occ = {1'b0, cnt_q} + (CW+1)'(trk_q[0]) + (CW+1)'(trk_q[1]);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    pass_d   = pass_q;
    passes_d = passes_q;
    issue    = 1'b0;
    push     = trk_q[1];
    pop      = data_out_valid && data_out_ready;
    case (state_q)
      IDLE: begin
        if (start) begin
          passes_d = num_passes;
          addr_d   = '0;
          pass_d   = '0;
          state_d  = (num_passes == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        if (occ < (CW+1)'(FIFO_DEPTH)) begin
          issue = 1'b1;
          if (addr_q == ADDR_WIDTH'(OUT_DEPTH - 1)) begin
            addr_d = '0;
            pass_d = pass_q + PASS_WIDTH'(1);
            if (pass_q + PASS_WIDTH'(1) == passes_q) state_d = DRAIN;
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
          end
        end
      end
      DRAIN: begin
        // Leave as soon as the final buffered beat handshakes this cycle.
        if (trk_q == 2'b00 && (cnt_q == '0 || (cnt_q == CW'(1) && pop))) state_d = FIN;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    rom_addr_d = issue ? addr_q : rom_addr_q;
    trk_d      = {trk_q[0], issue};

    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push) begin
      mem_d[wr_q] = rom_q;
      wr_d        = wr_q + PW'(1);
    end
    if (pop) rd_d = rd_q + PW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      rom_addr_q <= '0;
      pass_q     <= '0;
      passes_q   <= '0;
      trk_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rom_addr_q <= rom_addr_d;
      pass_q     <= pass_d;
      passes_q   <= passes_d;
      trk_q      <= trk_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign busy           = (state_q == RUN) || (state_q == DRAIN);
  assign done           = (state_q == FIN);
  assign rom_addr       = rom_addr_d;
  assign rom_ce         = 1'b1;
  assign data_out_valid = (cnt_q != '0);

  always_comb begin
    for (int j = 0; j < PARALLELISM; j++) begin
      data_out[j] = mem_q[rd_q][PRECISION*j +: PRECISION];
    end
  end
endmodule

// File: tb/tb_param_rom_stream_ctrl.sv
// Bench for param_rom_stream_ctrl: cycle table for one pass, hand-written corner sequences,
// and randomized-ready multi-pass runs scored against an expected-beat queue.
module tb_param_rom_stream_ctrl;
  localparam int PREC = 16;
  localparam int PAR  = 1;
  localparam int D    = 4;
  localparam int PW   = 8;
  localparam int FD   = 4;
  localparam int AW   = $clog2(D) + 1;

  logic            clk = 1'b0;
  logic            rst, start, busy, done, rom_ce, data_out_valid, data_out_ready;
  logic [PW-1:0]   num_passes;
  logic [AW-1:0]   rom_addr;
  logic [PREC-1:0] rom_q, rom_p1;
  logic [PREC-1:0] data_out [PAR];

  int errors = 0;
  int checks = 0;

  param_rom_stream_ctrl #(
    .PRECISION(PREC), .PARALLELISM(PAR), .OUT_DEPTH(D),
    .PASS_WIDTH(PW), .FIFO_DEPTH(FD), .ADDR_WIDTH(AW)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_passes(num_passes),
    .busy(busy), .done(done), .rom_addr(rom_addr), .rom_ce(rom_ce),
    .rom_q(rom_q), .data_out(data_out), .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready)
  );

  always #5 clk = ~clk;

  // ROM model: word i holds 0x10+i, two register stages of latency.
  always @(posedge clk) begin
    rom_p1 <= 16'h10 + PREC'(rom_addr);
    rom_q  <= rom_p1;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("fifo_bound", 32'(dut.cnt_q <= FD), 1);
      check("rom_ce", 32'(rom_ce), 1);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready=1; mode 1: random ready; mode 2: ready low in cycles 5..12.
  // xs >= 0 pulses a second start (num_passes=5) at that cycle.
  task automatic run_cmd(input int passes, input int mode, input int xs, input int budget);
    logic [15:0]   expq[$];
    logic [15:0]   pdat;
    logic [AW-1:0] paddr;
    int            last_hs = -100;
    int            wraps   = 0;
    bit            fin     = 0;
    bit            pstall  = 0;
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < D; i++) expq.push_back(16'h10 + 16'(i));
    paddr = rom_addr;
    pdat  = '0;
    for (int c = 0; c < budget && !fin; c++) begin
      start      = (c == 0) || (c == xs);
      num_passes = (c == xs) ? PW'(5) : PW'(passes);
      case (mode)
        0:       data_out_ready = 1'b1;
        1:       data_out_ready = 1'($urandom_range(0, 1));
        default: data_out_ready = !(c >= 5 && c <= 12);
      endcase
      @(negedge clk);
      if (pstall) begin
        check("stall_valid", 32'(data_out_valid), 1);
        check("stall_data", 32'(data_out[0]), 32'(pdat));
      end
      if (c >= 2 && rom_addr == '0 && paddr == AW'(D - 1)) wraps++;
      paddr = rom_addr;
      if (mode == 2 && c == 8)            check("bp_hold_word", 32'(data_out[0]), 32'h11);
      if (mode == 2 && c >= 5 && c <= 13) check("bp_addr_stall", 32'(rom_addr), 0);
      if (mode == 2 && c == 14)           check("bp_resume_addr", 32'(rom_addr), 1);
      if (done) begin
        fin = 1;
        check("done_timing", c, last_hs + 1);
        check("beats_left", expq.size(), 0);
        check("busy_in_fin", 32'(busy), 0);
      end else if (c > 0) begin
        check("busy_run", 32'(busy), 1);
      end
      if (data_out_valid && data_out_ready) begin
        if (expq.size() == 0) check("extra_beat", 1, 0);
        else                  check("beat", 32'(data_out[0]), 32'(expq.pop_front()));
        last_hs = c;
      end
      pstall = data_out_valid && !data_out_ready;
      pdat   = data_out[0];
      next_cycle();
    end
    start          = 1'b0;
    data_out_ready = 1'b1;
    if (!fin)      check("done_timeout", 0, 1);
    if (mode == 1) check("addr_wraps", wraps, passes - 1);
  endtask

  task automatic idle_check(input int n);
    for (int k = 0; k < n; k++) begin
      start = 1'b0;
      @(negedge clk);
      check("idle_valid", 32'(data_out_valid), 0);
      check("idle_busy", 32'(busy), 0);
      check("idle_done", 32'(done), 0);
      next_cycle();
    end
  endtask

  typedef struct {
    bit          start;
    bit          busy;
    bit          done;
    bit          vld;
    logic [15:0] dat;
    logic [AW-1:0] addr;
  } vec_t;

  vec_t vec [10];

  initial begin
    logic [AW-1:0] a0;
    vec[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h00, AW'(0)};
    vec[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h00, AW'(0)};
    vec[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h00, AW'(1)};
    vec[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h00, AW'(2)};
    vec[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h10, AW'(3)};
    vec[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h11, AW'(3)};
    vec[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h12, AW'(3)};
    vec[7] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h13, AW'(3)};
    vec[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h00, AW'(3)};
    vec[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h00, AW'(3)};

    rst = 1'b1; start = 1'b0; num_passes = '0; data_out_ready = 1'b1;
    repeat (3) next_cycle();
    @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_addr", 32'(rom_addr), 0);
    check("rst_valid", 32'(data_out_valid), 0);
    next_cycle();
    rst = 1'b0;

    // Single pass, cycle-exact.
    for (int c = 0; c < 10; c++) begin
      start = vec[c].start;
      num_passes = PW'(1);
      @(negedge clk);
      check("tbl_busy", 32'(busy), 32'(vec[c].busy));
      check("tbl_done", 32'(done), 32'(vec[c].done));
      check("tbl_valid", 32'(data_out_valid), 32'(vec[c].vld));
      check("tbl_addr", 32'(rom_addr), 32'(vec[c].addr));
      if (vec[c].vld) check("tbl_data", 32'(data_out[0]), 32'(vec[c].dat));
      next_cycle();
    end
    idle_check(2);

    run_cmd(2, 2, -1, 100);
    idle_check(2);

    run_cmd(3, 1, -1, 300);
    for (int r = 0; r < 4; r++) run_cmd($urandom_range(1, 4), 1, -1, 300);
    idle_check(2);

    run_cmd(1, 0, 6, 60);
    idle_check(4);

    // Zero passes, then a start during the done cycle must be ignored.
    a0 = rom_addr;
    start = 1'b1; num_passes = '0;
    @(negedge clk);
    check("zp_busy0", 32'(busy), 0);
    next_cycle();
    start = 1'b1; num_passes = PW'(1);
    @(negedge clk);
    check("zp_done", 32'(done), 1);
    check("zp_busy1", 32'(busy), 0);
    check("zp_valid", 32'(data_out_valid), 0);
    check("zp_addr", 32'(rom_addr), 32'(a0));
    next_cycle();
    start = 1'b0;
    @(negedge clk);
    check("zp_done_once", 32'(done), 0);
    check("fin_start_ignored", 32'(busy), 0);
    check("zp_addr_hold", 32'(rom_addr), 32'(a0));
    next_cycle();
    run_cmd(1, 0, -1, 40);

    // Reset in cycle 6 of a single pass.
    for (int c = 0; c < 6; c++) begin
      start = (c == 0); num_passes = PW'(1);
      next_cycle();
    end
    start = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("mr_pre_valid", 32'(data_out_valid), 1);
    check("mr_pre_data", 32'(data_out[0]), 32'h12);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("mr_valid", 32'(data_out_valid), 0);
    check("mr_busy", 32'(busy), 0);
    check("mr_done", 32'(done), 0);
    check("mr_addr", 32'(rom_addr), 0);
    next_cycle();
    idle_check(6);
    run_cmd(1, 0, -1, 40);
    idle_check(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors + 1);
    $fatal(1, "watchdog");
  end
endmodule
